// File: rtl/seg7_capture_if.sv
// seg7_capture_if: display read-back bus and capture event stream.
//   segment/dig_sel : multiplexed active-low segment pattern + one-hot strobe
//   out_*           : valid/ready event stream (digit index, 5-bit code, err)
//   overrun         : sticky dropped-event flag
// slave  = capture block, master = display/consumer side.
interface seg7_capture_if #(
  parameter int NDIG = 4,
  parameter int DIGW = (NDIG > 1) ? $clog2(NDIG) : 1
);
  logic [6:0]      segment;
  logic [NDIG-1:0] dig_sel;
  logic            out_valid;
  logic            out_ready;
  logic [DIGW-1:0] out_digit;
  logic [4:0]      out_code;
  logic            out_err;
  logic            overrun;

  modport slave (
    input  segment, dig_sel, out_ready,
    output out_valid, out_digit, out_code, out_err, overrun
  );

  modport master (
    output segment, dig_sel, out_ready,
    input  out_valid, out_digit, out_code, out_err, overrun
  );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: reads back a multiplexed active-low 7-segment bus, debounces
// each digit's pattern, re-encodes it to the 5-bit display code and reports
// only changed digits on a valid/ready stream.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : seg7_capture_if.slave (segment, dig_sel, out_ready in;
//           out_valid, out_digit, out_code, out_err, overrun out)

// Per-digit last-reported value and known flag.
module seg7_digit_store (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_i,
  input  logic [5:0] val_i,
  output logic       known_o,
  output logic [5:0] val_o
);
  logic       known_q;
  logic [5:0] val_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      known_q <= 1'b0;
      val_q   <= '0;
    end else if (wr_i) begin
      known_q <= 1'b1;
      val_q   <= val_i;
    end
  end

  assign known_o = known_q;
  assign val_o   = val_q;
endmodule

module seg7_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3,
  parameter int DIGW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_capture_if.slave  bus
);
  typedef struct packed {
    logic       err;
    logic [4:0] code;
  } enc_t;

  function automatic logic onehot(input logic [NDIG-1:0] v);
    return (v != '0) && ((v & (v - NDIG'(1))) == '0);
  endfunction

  // input sample stage and stability tracking
  logic [NDIG-1:0] sel_q;
  logic [6:0]      seg_q;
  logic [7:0]      cnt_q, cnt_d;
  logic            fired_q, fired_d;
  logic            chg, capture;

  assign chg     = {bus.dig_sel, bus.segment} != {sel_q, seg_q};
  assign capture = (cnt_q == 8'(STABLE)) && !fired_q && onehot(sel_q);

  // cnt describes how long the value now entering s_q has been held.
  // fired keeps a saturated counter from re-capturing the same window.
  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    if (!onehot(bus.dig_sel)) begin
      cnt_d   = '0;
      fired_d = 1'b0;
    end else if (chg) begin
      cnt_d   = 8'd1;
      fired_d = 1'b0;
    end else begin
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      if (capture)        fired_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q   <= '0;
      seg_q   <= '0;
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      sel_q   <= bus.dig_sel;
      seg_q   <= bus.segment;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

  // pattern -> display code; aliased letters share the lower code's pattern
  enc_t enc;
  always_comb begin
    enc = '{err: 1'b0, code: 5'h00};
    case (seg_q)
      7'h40: enc.code = 5'h00;
      7'h79: enc.code = 5'h01;
      7'h24: enc.code = 5'h02;
      7'h30: enc.code = 5'h03;
      7'h19: enc.code = 5'h04;
      7'h12: enc.code = 5'h05;
      7'h02: enc.code = 5'h06;
      7'h78: enc.code = 5'h07;
      7'h00: enc.code = 5'h08;
      7'h18: enc.code = 5'h09;
      7'h08: enc.code = 5'h0A;
      7'h03: enc.code = 5'h0B;
      7'h27: enc.code = 5'h0C;
      7'h21: enc.code = 5'h0D;
      7'h06: enc.code = 5'h0E;
      7'h0E: enc.code = 5'h0F;
      7'h3E: enc.code = 5'h10;
      7'h0C: enc.code = 5'h12;
      7'h01: enc.code = 5'h16;
      7'h23: enc.code = 5'h1D;
      7'h4F: enc.code = 5'h1E;
      7'h3F: enc.code = 5'h19;
      default: enc.err = 1'b1;
    endcase
  end

  logic [DIGW-1:0] dig_idx;
  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < NDIG; i++)
      if (sel_q[i]) dig_idx = DIGW'(i);
  end

  // per-digit change filter store
  logic [NDIG-1:0]      st_known;
  logic [NDIG-1:0][5:0] st_val;
  logic [NDIG-1:0]      st_wr;
  logic                 evt, free, ld;

  assign evt  = capture && (!st_known[dig_idx] || (st_val[dig_idx] != enc));
  assign free = !bus.out_valid || bus.out_ready;
  assign ld   = evt && free;

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_dig
      assign st_wr[g] = ld && (dig_idx == DIGW'(g));
      seg7_digit_store u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (st_wr[g]),
        .val_i   (enc),
        .known_o (st_known[g]),
        .val_o   (st_val[g])
      );
    end
  endgenerate

  // output stream registers
  logic            valid_q, err_q, ovr_q;
  logic [DIGW-1:0] digit_q;
  logic [4:0]      code_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      digit_q <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (ld) begin
        valid_q <= 1'b1;
        digit_q <= dig_idx;
        code_q  <= enc.code;
        err_q   <= enc.err;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
      // stalled output: event is lost, store untouched so the digit re-reports
      if (evt && !free) ovr_q <= 1'b1;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_digit = digit_q;
  assign bus.out_code  = code_q;
  assign bus.out_err   = err_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;
  localparam int NDIG = 4, STABLE = 3, DIGW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_capture_if #(.NDIG(NDIG), .DIGW(DIGW)) bus ();
  seg7_capture #(.NDIG(NDIG), .STABLE(STABLE), .DIGW(DIGW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { int dig; logic err; logic [4:0] code; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0, ev_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // reference encode table: 6 bits {err, code}, unlisted patterns are errors
  int pats[22]  = '{'h40,'h79,'h24,'h30,'h19,'h12,'h02,'h78,'h00,'h18,'h08,
                    'h03,'h27,'h21,'h06,'h0E,'h3E,'h0C,'h01,'h23,'h4F,'h3F};
  int codes[22] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,
                    'h10,'h12,'h16,'h1D,'h1E,'h19};
  logic [5:0] enc_tab [128];
  initial begin
    for (int i = 0; i < 128; i++) enc_tab[i] = 6'h20;
    for (int i = 0; i < 22; i++) enc_tab[pats[i]] = 6'(codes[i]);
  end

  // reference model: a value held STABLE samples in a row (one-hot strobe)
  // is one capture; it is reported if it is news for that digit and the
  // stream can take it, otherwise dropped with overrun
  int                run;
  logic [NDIG+6:0]   last;
  logic              cap_pend, valid_m, ovr_m;
  int                cap_dig;
  logic [6:0]        cap_seg;
  logic              known_m [NDIG];
  logic [5:0]        val_m [NDIG];

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      run = 0; last = '0; cap_pend = 0; valid_m = 0; ovr_m = 0;
      for (int i = 0; i < NDIG; i++) begin known_m[i] = 0; val_m[i] = '0; end
      exp_q.delete();
    end else begin
      logic [5:0] e;
      logic       news;
      news = 0;
      if (cap_pend) begin
        e = enc_tab[cap_seg];
        news = !known_m[cap_dig] || (val_m[cap_dig] != e);
      end
      if (news && (!valid_m || bus.out_ready)) begin
        exp_q.push_back('{cap_dig, e[5], e[4:0]});
        known_m[cap_dig] = 1; val_m[cap_dig] = e; valid_m = 1;
      end else begin
        if (news) ovr_m = 1;
        if (valid_m && bus.out_ready) valid_m = 0;
      end
      if ($countones(bus.dig_sel) != 1) run = 0;
      else if ({bus.dig_sel, bus.segment} == last) run++;
      else run = 1;
      last = {bus.dig_sel, bus.segment};
      cap_pend = (run == STABLE);
      cap_seg  = bus.segment;
      cap_dig  = 0;
      for (int i = 0; i < NDIG; i++) if (bus.dig_sel[i]) cap_dig = i;
    end
  end

  // monitor: checks the stream against the scoreboard away from the edge
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("out_valid", bus.out_valid, valid_m);
      chk("overrun", bus.overrun, ovr_m);
      if (bus.out_valid) begin
        chk("event_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("out_digit", bus.out_digit, exp_q[0].dig);
          chk("out_err", bus.out_err, exp_q[0].err);
          chk("out_code", bus.out_code, exp_q[0].code);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            ev_cnt++;
          end
        end
      end
    end
  end

  task automatic drive(input logic [NDIG-1:0] d, input logic [6:0] s,
                       input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      bus.dig_sel = d; bus.segment = s; bus.out_ready = r;
      @(posedge clk); #1;
    end
  endtask

  int e0;
  int scan_pat[4] = '{'h40, 'h79, 'h12, 'h4F};

  initial begin
    bus.dig_sel = '0; bus.segment = 7'h7F; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // reset with toggling inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) drive(NDIG'($urandom), 7'($urandom), 1'b1, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_digit", bus.out_digit, 0);
    chk("rst_code", bus.out_code, 0);
    chk("rst_err", bus.out_err, 0);
    chk("rst_overrun", bus.overrun, 0);
    rst_n = 1'b1;

    // first capture latency
    drive(4'b0001, 7'h24, 1'b1, 3);
    chk("lat_before", bus.out_valid, 0);
    drive(4'b0001, 7'h24, 1'b1, 1);
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_code", bus.out_code, 2);
    chk("lat_digit", bus.out_digit, 0);
    drive(4'b0001, 7'h24, 1'b1, 10);
    chk("hold_events", ev_cnt, 1);

    // scan 3 rounds, then one changed digit
    e0 = ev_cnt;
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) drive(NDIG'(1 << d), 7'(scan_pat[d]), 1'b1, 5);
    chk("scan_events", ev_cnt - e0, 4);
    e0 = ev_cnt;
    for (int d = 0; d < 4; d++)
      drive(NDIG'(1 << d), (d == 2) ? 7'h0C : 7'(scan_pat[d]), 1'b1, 5);
    chk("rescan_events", ev_cnt - e0, 1);

    // blank/invalid pattern
    e0 = ev_cnt;
    drive(4'b0010, 7'h7F, 1'b1, 4);
    chk("err_flag", bus.out_err, 1);
    chk("err_code", bus.out_code, 0);
    drive(4'b0010, 7'h7F, 1'b1, 1);
    drive(4'b0001, 7'h40, 1'b1, 5);
    drive(4'b0010, 7'h7F, 1'b1, 5);
    chk("err_repeat_events", ev_cnt - e0, 1);
    drive(4'b0010, 7'h3F, 1'b1, 5);
    chk("err_fix_events", ev_cnt - e0, 2);

    // stalled output: second digit dropped
    e0 = ev_cnt;
    drive(4'b0001, 7'h24, 1'b0, 5);
    drive(4'b1000, 7'h30, 1'b0, 5);
    chk("stall_overrun", bus.overrun, 1);
    chk("stall_code", bus.out_code, 2);
    chk("stall_digit", bus.out_digit, 0);
    drive(4'b0000, 7'h7F, 1'b1, 2);
    drive(4'b1000, 7'h30, 1'b1, 5);
    chk("stall_events", ev_cnt - e0, 2);
    chk("overrun_sticky", bus.overrun, 1);

    // no capture on bad strobes or fast-changing input
    e0 = ev_cnt;
    drive(4'b0000, 7'h24, 1'b1, 10);
    drive(4'b0011, 7'h24, 1'b1, 10);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 7'h12, 1'b1, 2);
      drive(4'b0001, 7'h30, 1'b1, 2);
    end
    chk("no_capture_events", ev_cnt - e0, 0);

    // randomized traffic with one mid-run reset
    for (int n = 0; n < 400; n++) begin
      logic [NDIG-1:0] d;
      logic [6:0]      s;
      int              sel, hold;
      sel  = $urandom_range(0, 9);
      d    = (sel == 0) ? NDIG'(0) : (sel == 1) ? NDIG'(6)
                                   : NDIG'(1 << $urandom_range(0, NDIG - 1));
      s    = ($urandom_range(0, 4) == 0) ? 7'($urandom)
                                         : 7'(pats[$urandom_range(0, 21)]);
      hold = $urandom_range(1, 6);
      for (int c = 0; c < hold; c++) drive(d, s, $urandom_range(0, 3) != 0, 1);
      if (n == 200) begin
        rst_n = 1'b0;
        drive(d, s, 1'b1, 2);
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_overrun", bus.overrun, 0);
        rst_n = 1'b1;
      end
    end

    drive(4'b0000, 7'h7F, 1'b1, 6);
    chk("drain_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
